// File: rtl/axi_lite_slv_comb_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_slv_comb_responder
// Brief    : AXI4-Lite register-file slave with programmable response latency
//            and saturating write/read/error statistics counters.
// Revision : 1.0
// ============================================================================
module axi_lite_slv_comb_responder #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int RESP_LAT = 2,
    parameter int CNT_W    = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [CNT_W-1:0]      wr_count,
    output logic [CNT_W-1:0]      rd_count,
    output logic [CNT_W-1:0]      err_count
);

    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_OFF_W  = $clog2(c_STRB_W);
    localparam int c_IDX_W  = ADDR_W - c_OFF_W;
    localparam int c_SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] c_NUM_REGS = NUM_REGS;
    localparam logic [3:0]  c_LAT      = 4'(RESP_LAT);

    localparam logic [2:0] W_IDLE   = 3'd0;
    localparam logic [2:0] W_HAVE_A = 3'd1;
    localparam logic [2:0] W_HAVE_D = 3'd2;
    localparam logic [2:0] W_WAIT   = 3'd3;
    localparam logic [2:0] W_RESP   = 3'd4;
    localparam logic [2:0] c_W_POST = (RESP_LAT == 0) ? W_RESP : W_WAIT;

    localparam logic [1:0] R_IDLE   = 2'd0;
    localparam logic [1:0] R_WAIT   = 2'd1;
    localparam logic [1:0] R_RESP   = 2'd2;
    localparam logic [1:0] c_R_POST = (RESP_LAT == 0) ? R_RESP : R_WAIT;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(inc);
        sat_add = s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [NUM_REGS-1:0][DATA_W-1:0] w_regs;

    // ---------------- write path ----------------
    logic [2:0]          r_wstate, w_wstate_nxt;
    logic                r_awready, r_wready;
    logic [ADDR_W-1:0]   r_awaddr_q;
    logic [DATA_W-1:0]   r_wdata_q;
    logic [c_STRB_W-1:0] r_wstrb_q;
    logic [3:0]          r_wlat, w_wlat_dec;
    logic [1:0]          r_bresp;
    logic                w_aw_hs, w_w_hs, w_b_hs, w_commit, w_wr_in;
    logic [ADDR_W-1:0]   w_c_addr;
    logic [DATA_W-1:0]   w_c_data;
    logic [c_STRB_W-1:0] w_c_strb;
    logic [c_IDX_W-1:0]  w_c_idx;
    logic [c_SEL_W-1:0]  w_c_sel;

    assign w_aw_hs    = s_awvalid & r_awready;
    assign w_w_hs     = s_wvalid & r_wready;
    assign w_b_hs     = (r_wstate == W_RESP) & s_bready;
    assign w_commit   = ((r_wstate == W_IDLE) & w_aw_hs & w_w_hs) |
                        ((r_wstate == W_HAVE_A) & w_w_hs) |
                        ((r_wstate == W_HAVE_D) & w_aw_hs);
    assign w_c_addr   = (r_wstate == W_HAVE_A) ? r_awaddr_q : s_awaddr;
    assign w_c_data   = (r_wstate == W_HAVE_D) ? r_wdata_q : s_wdata;
    assign w_c_strb   = (r_wstate == W_HAVE_D) ? r_wstrb_q : s_wstrb;
    assign w_c_idx    = w_c_addr[ADDR_W-1:c_OFF_W];
    assign w_c_sel    = w_c_idx[c_SEL_W-1:0];
    assign w_wr_in    = (32'(w_c_idx) < c_NUM_REGS);
    assign w_wlat_dec = r_wlat - 4'd1;

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) w_wstate_nxt = c_W_POST;
                else if (w_aw_hs)      w_wstate_nxt = W_HAVE_A;
                else if (w_w_hs)       w_wstate_nxt = W_HAVE_D;
            end
            W_HAVE_A: if (w_w_hs)  w_wstate_nxt = c_W_POST;
            W_HAVE_D: if (w_aw_hs) w_wstate_nxt = c_W_POST;
            // leave as the counter reaches zero so bvalid lands RESP_LAT+1 cycles on
            W_WAIT:   if (w_wlat_dec == 4'd0) w_wstate_nxt = W_RESP;
            W_RESP:   if (s_bready) w_wstate_nxt = W_IDLE;
            default:  w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wstate   <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_awaddr_q <= '0;
            r_wdata_q  <= '0;
            r_wstrb_q  <= '0;
            r_wlat     <= 4'd0;
            r_bresp    <= 2'b00;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_D);
            r_wready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_A);
            if (w_aw_hs) r_awaddr_q <= s_awaddr;
            if (w_w_hs) begin
                r_wdata_q <= s_wdata;
                r_wstrb_q <= s_wstrb;
            end
            if (w_commit) begin
                r_wlat  <= c_LAT;
                r_bresp <= w_wr_in ? 2'b00 : 2'b10;
            end else if (r_wstate == W_WAIT) begin
                r_wlat <= w_wlat_dec;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        logic [DATA_W-1:0] r_q;
        always_ff @(posedge clock) begin
            if (reset) begin
                r_q <= RESET_VAL;
            end else if (w_commit && w_wr_in && (w_c_sel == c_SEL_W'(i))) begin
                for (int b = 0; b < c_STRB_W; b++) begin
                    if (w_c_strb[b]) r_q[8*b +: 8] <= w_c_data[8*b +: 8];
                end
            end
        end
        assign w_regs[i] = r_q;
    end

    // ---------------- read path ----------------
    logic [1:0]         r_rstate, w_rstate_nxt;
    logic               r_arready;
    logic [3:0]         r_rlat, w_rlat_dec;
    logic [1:0]         r_rresp;
    logic [DATA_W-1:0]  r_rdata;
    logic               w_ar_hs, w_r_hs, w_rd_in;
    logic [c_IDX_W-1:0] w_r_idx;
    logic [c_SEL_W-1:0] w_r_sel;

    assign w_ar_hs    = s_arvalid & r_arready;
    assign w_r_hs     = (r_rstate == R_RESP) & s_rready;
    assign w_r_idx    = s_araddr[ADDR_W-1:c_OFF_W];
    assign w_r_sel    = w_r_idx[c_SEL_W-1:0];
    assign w_rd_in    = (32'(w_r_idx) < c_NUM_REGS);
    assign w_rlat_dec = r_rlat - 4'd1;

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = c_R_POST;
            R_WAIT:  if (w_rlat_dec == 4'd0) w_rstate_nxt = R_RESP;
            R_RESP:  if (s_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rlat    <= 4'd0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            if (w_ar_hs) begin
                r_rlat  <= c_LAT;
                r_rresp <= w_rd_in ? 2'b00 : 2'b10;
                r_rdata <= w_rd_in ? w_regs[w_r_sel] : '0;
            end else if (r_rstate == R_WAIT) begin
                r_rlat <= w_rlat_dec;
            end
        end
    end

    // ---------------- statistics ----------------
    logic [CNT_W-1:0] r_wr_cnt, r_rd_cnt, r_err_cnt;
    logic             w_b_err, w_r_err;

    assign w_b_err = w_b_hs & (r_bresp != 2'b00);
    assign w_r_err = w_r_hs & (r_rresp != 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            r_wr_cnt  <= sat_add(r_wr_cnt, {1'b0, w_b_hs});
            r_rd_cnt  <= sat_add(r_rd_cnt, {1'b0, w_r_hs});
            r_err_cnt <= sat_add(r_err_cnt, 2'(w_b_err) + 2'(w_r_err));
        end
    end

    logic w_unused;
    assign w_unused = ^{w_c_addr[c_OFF_W-1:0], s_araddr[c_OFF_W-1:0]};

    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_bvalid  = (r_wstate == W_RESP);
    assign s_bresp   = r_bresp;
    assign s_arready = r_arready;
    assign s_rvalid  = (r_rstate == R_RESP);
    assign s_rresp   = r_rresp;
    assign s_rdata   = r_rdata;
    assign wr_count  = r_wr_cnt;
    assign rd_count  = r_rd_cnt;
    assign err_count = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slv_comb_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_slv_comb_responder
// Brief    : Directed scoreboard bench for the AXI4-Lite register responder.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_slv_comb_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] s_awaddr;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid, s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;
    logic [11:0] s_araddr;
    logic        s_arvalid, s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid, s_rready;
    logic [15:0] wr_count, rd_count, err_count;

    axi_lite_slv_comb_responder #(
        .ADDR_W(12), .DATA_W(32), .NUM_REGS(16), .RESP_LAT(2), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    int          e_wr = 0, e_rd = 0, e_err = 0;
    logic [1:0]  m_eb;
    logic [33:0] m_er;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void to_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: handshake wait expired", nm);
    endfunction

    // response monitor: pops expected responses as the DUT presents them
    always @(negedge clock) begin
        if (reset) begin
            e_wr = 0; e_rd = 0; e_err = 0;
        end else begin
            if (s_bvalid && s_bready) begin
                if (bq.size() == 0) begin
                    to_fail("b_unexpected");
                end else begin
                    m_eb = bq.pop_front();
                    chk("bresp", {62'd0, s_bresp}, {62'd0, m_eb});
                    e_wr++;
                    if (m_eb != 2'b00) e_err++;
                end
            end
            if (s_rvalid && s_rready) begin
                if (rq.size() == 0) begin
                    to_fail("r_unexpected");
                end else begin
                    m_er = rq.pop_front();
                    chk("rresp", {62'd0, s_rresp}, {62'd0, m_er[33:32]});
                    chk("rdata", {32'd0, s_rdata}, {32'd0, m_er[31:0]});
                    e_rd++;
                    if (m_er[33:32] != 2'b00) e_err++;
                end
            end
        end
    end

    task automatic do_wr_both(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st);
        int n = 0;
        s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(negedge clock);
        while (!(s_awready && s_wready) && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) to_fail("wr_accept");
        @(posedge clock); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
    endtask

    task automatic do_rd(input logic [11:0] a);
        int n = 0;
        s_araddr = a; s_arvalid = 1'b1;
        @(negedge clock);
        while (!s_arready && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) to_fail("rd_accept");
        @(posedge clock); #1;
        s_arvalid = 1'b0;
    endtask

    // counts cycles from the handshake cycle until valid is seen
    task automatic wait_lat(input bit is_r, input int exp, input string nm);
        int n = 1;
        @(negedge clock);
        while (!(is_r ? s_rvalid : s_bvalid) && n < 50) begin @(negedge clock); n++; end
        chk(nm, 64'(n), 64'(exp));
    endtask

    task automatic write_full(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st, input logic [1:0] resp);
        bq.push_back(resp);
        do_wr_both(a, d, st);
        wait_lat(1'b0, 3, "b_latency");
        @(posedge clock); #1;
    endtask

    task automatic read_full(input logic [11:0] a, input logic [1:0] resp, input logic [31:0] d);
        rq.push_back({resp, d});
        do_rd(a);
        wait_lat(1'b1, 3, "r_latency");
        @(posedge clock); #1;
    endtask

    task automatic chk_counts(input int w, input int r, input int e);
        @(negedge clock);
        chk("wr_count", {48'd0, wr_count}, 64'(w));
        chk("rd_count", {48'd0, rd_count}, 64'(r));
        chk("err_count", {48'd0, err_count}, 64'(e));
        @(posedge clock); #1;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0; s_bready = 1'b1; s_rready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_awready", {63'd0, s_awready}, 64'd0);
        chk("rst_wready",  {63'd0, s_wready},  64'd0);
        chk("rst_arready", {63'd0, s_arready}, 64'd0);
        chk("rst_bvalid",  {63'd0, s_bvalid},  64'd0);
        chk("rst_rvalid",  {63'd0, s_rvalid},  64'd0);
        chk("rst_rdata",   {32'd0, s_rdata},   64'd0);
        chk("rst_resps",   {60'd0, s_bresp, s_rresp}, 64'd0);
        chk("rst_counts",  {16'd0, wr_count, rd_count, err_count}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // simultaneous AW/W, then readback
        write_full(12'h004, 32'hDEADBEEF, 4'hF, 2'b00);
        read_full(12'h004, 2'b00, 32'hDEADBEEF);

        // W ahead of AW with partial strobes
        write_full(12'h008, 32'hAAAAAAAA, 4'hF, 2'b00);
        bq.push_back(2'b00);
        s_wdata = 32'h12345678; s_wstrb = 4'h3; s_wvalid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!s_wready && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) to_fail("w_accept");
        @(posedge clock); #1;
        s_wvalid = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk("have_d_wready",  {63'd0, s_wready},  64'd0);
            chk("have_d_awready", {63'd0, s_awready}, 64'd1);
        end
        @(posedge clock); #1;
        s_awaddr = 12'h008; s_awvalid = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;
        s_awvalid = 1'b0;
        wait_lat(1'b0, 3, "b_latency_split");
        chk("resp_wready", {63'd0, s_wready}, 64'd0);
        @(posedge clock); #1;
        read_full(12'h008, 2'b00, 32'hAAAA5678);
        chk_counts(3, 2, 0);

        // out-of-range accesses
        write_full(12'h040, 32'h99999999, 4'hF, 2'b10);
        chk_counts(4, 2, 1);
        read_full(12'h000, 2'b00, 32'h00000000);
        read_full(12'h040, 2'b10, 32'h00000000);
        chk_counts(4, 4, 2);

        // back-pressure on B and R
        s_bready = 1'b0;
        bq.push_back(2'b10);
        do_wr_both(12'h044, 32'h00001234, 4'hF);
        wait_lat(1'b0, 3, "b_latency_stall");
        repeat (10) begin
            @(negedge clock);
            chk("stall_bvalid",  {63'd0, s_bvalid},  64'd1);
            chk("stall_bresp",   {62'd0, s_bresp},   64'd2);
            chk("stall_awready", {63'd0, s_awready}, 64'd0);
            chk("stall_wready",  {63'd0, s_wready},  64'd0);
        end
        @(posedge clock); #1;
        s_bready = 1'b1;
        @(posedge clock); #1;
        s_rready = 1'b0;
        rq.push_back({2'b00, 32'hDEADBEEF});
        do_rd(12'h004);
        wait_lat(1'b1, 3, "r_latency_stall");
        repeat (10) begin
            @(negedge clock);
            chk("stall_rvalid",  {63'd0, s_rvalid},  64'd1);
            chk("stall_rdata",   {32'd0, s_rdata},   64'hDEADBEEF);
            chk("stall_arready", {63'd0, s_arready}, 64'd0);
        end
        @(posedge clock); #1;
        s_rready = 1'b1;
        @(posedge clock); #1;
        chk_counts(5, 5, 3);

        // read and committing write on the same edge
        bq.push_back(2'b00);
        rq.push_back({2'b00, 32'h00000000});
        s_awaddr = 12'h00C; s_wdata = 32'h5555AAAA; s_wstrb = 4'hF; s_araddr = 12'h00C;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!(s_awready && s_wready && s_arready) && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) to_fail("conc_accept");
        @(posedge clock); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        wait_lat(1'b0, 3, "b_latency_conc");
        chk("conc_rvalid", {63'd0, s_rvalid}, 64'd1);
        @(posedge clock); #1;
        read_full(12'h00C, 2'b00, 32'h5555AAAA);
        chk_counts(6, 7, 3);
        chk("model_wr", {48'd0, wr_count}, 64'(e_wr));
        chk("model_err", {48'd0, err_count}, 64'(e_err));

        // reset while a write is waiting for its response
        do_wr_both(12'h010, 32'h00000077, 4'hF);
        @(negedge clock);
        chk("wait_bvalid", {63'd0, s_bvalid}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (6) begin
            @(negedge clock);
            chk("post_rst_bvalid", {63'd0, s_bvalid}, 64'd0);
        end
        @(posedge clock); #1;
        chk_counts(0, 0, 0);
        read_full(12'h004, 2'b00, 32'h00000000);
        read_full(12'h010, 2'b00, 32'h00000000);
        write_full(12'h010, 32'h0F0F0F0F, 4'hF, 2'b00);
        read_full(12'h010, 2'b00, 32'h0F0F0F0F);
        chk_counts(1, 3, 0);
        chk("model_rd", {48'd0, rd_count}, 64'(e_rd));

        repeat (3) @(posedge clock);
        chk("bq_drained", 64'(bq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
